// File: rtl/mdu_sequencer.sv
// mdu_sequencer
// Moore FSM that sequences the iterative multiply/divide datapath in the EX stage.
// It accepts one MDU op while EX holds it and steps the datapath through load,
// N iterations and done. It reports completion to the pipeline and honours the
// MA-stage stall and flush. A divide-by-zero skips the iterations entirely.
//
// Ports
//   s_clk_i       clock
//   s_reset_i     synchronous active-high reset
//   s_start_i     EX holds a valid MDU op (held while the op is resident)
//   s_div_i       op is divide/remainder (sampled in IDLE with start)
//   s_op2_zero_i  divisor is zero (sampled in IDLE with start)
//   s_stall_i     MA-stage stall (only holds DONE)
//   s_flush_i     MA-stage flush
//   s_load_o      datapath loads operands
//   s_iter_en_o   datapath performs one iteration
//   s_last_o      current iteration is the final one
//   s_count_o     iteration index, 0 on the first RUN cycle
//   s_bypass_o    divide-by-zero short path select
//   s_busy_o      LOAD or RUN
//   s_finished_o  result valid (DONE)
module mdu_sequencer #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic             s_clk_i,
    input  logic             s_reset_i,
    input  logic             s_start_i,
    input  logic             s_div_i,
    input  logic             s_op2_zero_i,
    input  logic             s_stall_i,
    input  logic             s_flush_i,
    output logic             s_load_o,
    output logic             s_iter_en_o,
    output logic             s_last_o,
    output logic [CNT_W-1:0] s_count_o,
    output logic             s_bypass_o,
    output logic             s_busy_o,
    output logic             s_finished_o
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    // Limits are stored as limit-1 so they fit in CNT_W bits even at 2**CNT_W.
    localparam logic [CNT_W-1:0] MulLast = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DivLast = CNT_W'(DIV_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic             bypass_q, bypass_d;
    logic             at_last;
    logic             abort;

    assign at_last = (count_q == last_q);
    // The op leaving EX without a flush is treated exactly like a flush.
    assign abort   = s_flush_i || ((state_q != StIdle) && !s_start_i);

    // State register
    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            state_q  <= StIdle;
            count_q  <= '0;
            last_q   <= '0;
            bypass_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            last_q   <= last_d;
            bypass_q <= bypass_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        last_d   = last_q;
        bypass_d = bypass_q;
        if (abort) begin
            state_d  = StIdle;
            count_d  = '0;
            bypass_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (s_start_i) begin
                        state_d  = StLoad;
                        count_d  = '0;
                        last_d   = s_div_i ? DivLast : MulLast;
                        bypass_d = s_div_i & s_op2_zero_i;
                    end
                end
                StLoad: begin
                    state_d = bypass_q ? StDone : StRun;
                    count_d = '0;
                end
                StRun: begin
                    // Count holds on the last iteration so DONE still shows it.
                    if (at_last) begin
                        state_d = StDone;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                StDone: begin
                    if (!s_stall_i) begin
                        state_d  = StIdle;
                        count_d  = '0;
                        bypass_d = 1'b0;
                    end
                end
                default: begin
                    state_d  = StIdle;
                    count_d  = '0;
                    bypass_d = 1'b0;
                end
            endcase
        end
    end

    // Output decode: from state and registers only
    always_comb begin
        s_load_o     = 1'b0;
        s_iter_en_o  = 1'b0;
        s_last_o     = 1'b0;
        s_busy_o     = 1'b0;
        s_finished_o = 1'b0;
        s_count_o    = count_q;
        s_bypass_o   = bypass_q;
        case (state_q)
            StLoad: begin
                s_load_o = 1'b1;
                s_busy_o = 1'b1;
            end
            StRun: begin
                s_iter_en_o = 1'b1;
                s_busy_o    = 1'b1;
                s_last_o    = at_last;
            end
            StDone: begin
                s_finished_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer. Each step drives the inputs for one cycle
// and pushes the outputs expected after the next clock edge; the sample taken
// after that edge pops and compares.
module tb_mdu_sequencer;

    localparam int CW = 6;

    // {load, iter_en, last, bypass, busy, finished, count}
    typedef logic [CW+5:0] vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          div = 1'b0;
    logic          op2_zero = 1'b0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          load, iter_en, last, bypass, busy, finished;
    logic [CW-1:0] count;

    int   checks = 0;
    int   failures = 0;
    vec_t exp_q[$];

    mdu_sequencer #(
        .MUL_CYCLES(4),
        .DIV_CYCLES(32),
        .CNT_W     (CW)
    ) dut (
        .s_clk_i     (clk),
        .s_reset_i   (reset),
        .s_start_i   (start),
        .s_div_i     (div),
        .s_op2_zero_i(op2_zero),
        .s_stall_i   (stall),
        .s_flush_i   (flush),
        .s_load_o    (load),
        .s_iter_en_o (iter_en),
        .s_last_o    (last),
        .s_count_o   (count),
        .s_bypass_o  (bypass),
        .s_busy_o    (busy),
        .s_finished_o(finished)
    );

    always #5 clk = ~clk;

    // Expected outputs n cycles after start is first seen in IDLE, for an
    // undisturbed op with `lim` iterations and bypass flag `b`.
    function automatic vec_t nominal(input int n, input int lim, input bit b);
        logic          e_load, e_it, e_last, e_bp, e_busy, e_fin;
        logic [CW-1:0] e_cnt;
        e_load = 0; e_it = 0; e_last = 0; e_bp = 0; e_busy = 0; e_fin = 0;
        e_cnt = '0;
        if (n == 1) begin
            e_load = 1; e_busy = 1; e_bp = b;
        end else if (b && n == 2) begin
            e_fin = 1; e_bp = 1;
        end else if (!b && n >= 2 && n <= lim + 1) begin
            e_it = 1; e_busy = 1; e_cnt = CW'(n - 2); e_last = (n == lim + 1);
        end else if (!b && n == lim + 2) begin
            e_fin = 1; e_cnt = CW'(lim - 1);
        end
        return {e_load, e_it, e_last, e_bp, e_busy, e_fin, e_cnt};
    endfunction

    task automatic check(input string tag);
        vec_t obs, e;
        obs = {load, iter_en, last, bypass, busy, finished, count};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard empty observed=%h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    // Drive one cycle of inputs, expect `exp_next` after the following edge.
    task automatic cyc(input bit st, input bit dv, input bit z, input bit stl,
                       input bit fl, input bit rst, input vec_t exp_next,
                       input string tag);
        start = st; div = dv; op2_zero = z; stall = stl; flush = fl; reset = rst;
        exp_q.push_back(exp_next);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    // Undisturbed op; div/op2_zero are inverted after cycle 0 to show they
    // are ignored once the op is latched.
    task automatic run_op(input bit dv, input bit z, input int lim, input int total,
                          input string tag);
        bit b;
        int hold;
        b = dv & z;
        hold = b ? 2 : lim + 2;
        for (int c = 0; c < total; c++) begin
            cyc(c <= hold, (c == 0) ? dv : ~dv, (c == 0) ? z : ~z, 1'b0, 1'b0, 1'b0,
                nominal(c + 1, lim, b), $sformatf("%s@%0d", tag, c + 1));
            if (!b && count > CW'(lim - 1)) begin
                checks++;
                failures++;
                $error("FAIL %s_count_max@%0d observed=%0d expected<=%0d", tag, c + 1,
                       count, lim - 1);
            end else begin
                checks++;
            end
        end
    endtask

    initial begin
        vec_t e;

        // Reset state
        cyc(0, 0, 0, 0, 0, 1, '0, "reset0");
        cyc(1, 1, 1, 0, 0, 1, '0, "reset1");

        // MUL, DIV, DIV-by-zero
        run_op(1'b0, 1'b0, 4, 8, "mul");
        run_op(1'b1, 1'b0, 32, 36, "div");
        run_op(1'b1, 1'b1, 32, 5, "div0");

        // MUL with stall held over cycles 4..7: DONE holds through cycle 8
        for (int c = 0; c < 10; c++) begin
            int n;
            n = c + 1;
            if (n <= 6) e = nominal(n, 4, 0);
            else if (n <= 8) e = nominal(6, 4, 0);
            else e = '0;
            cyc(c <= 8, 0, 0, (c >= 4 && c <= 7), 0, 0, e, $sformatf("stall@%0d", n));
        end

        // DIV flushed at cycle 10 (start held, div-by-zero inputs not latched),
        // then a new MUL started at cycle 11
        for (int c = 0; c < 20; c++) begin
            int n;
            n = c + 1;
            if (n <= 10) e = nominal(n, 32, 0);
            else if (n == 11) e = '0;
            else e = nominal(n - 11, 4, 0);
            if (c <= 10)
                cyc(1, (c == 0 || c == 10), (c == 10), 0, (c == 10), 0, e,
                    $sformatf("flush@%0d", n));
            else
                cyc(c <= 17, 0, 0, 0, 0, 0, e, $sformatf("flush_mul@%0d", n));
        end

        // Reset at cycle 5 of a DIV; start held reloads at 7; start dropped at
        // 7 aborts to IDLE at 8
        for (int c = 0; c < 9; c++) begin
            int n;
            n = c + 1;
            if (n <= 5) e = nominal(n, 32, 0);
            else if (n == 7) e = nominal(1, 32, 0);
            else e = '0;
            cyc(c <= 6, (c == 0 || c == 6), 0, 0, 0, (c == 5), e,
                $sformatf("rst@%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
